// File: rtl/run_detect_fsm.sv
// run_detect_fsm
//   One-hot Moore run detector. It asserts z once the serial input w has held
//   the same value for RUN_LEN consecutive accepted samples. Detection of zero
//   runs and one runs is enabled separately through mode. It also keeps a
//   saturating count of detection events and recovers from a corrupted
//   (non-one-hot) state register.
//
// Parameters
//   RUN_LEN     required run length (>= 2)
//   CNT_W       width of the detection event counter
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset, highest priority
//   w_valid     sample qualifier; w is consumed only when high
//   w           serial data bit
//   mode        bit0 enables zero-run detection, bit1 enables one-run detection
//   clear_count synchronous clear of det_count (wins over an increment)
//   z           detection output, decoded from state and mode only
//   run_zero    state is Z_N (ignores mode)
//   run_one     state is O_N (ignores mode)
//   states      raw one-hot state {O_N..O1, Z_N..Z1, IDLE}
//   det_count   saturating detection event count
//   onehot_err  one-cycle pulse after an illegal state was recovered to IDLE
module run_detect_fsm #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 w_valid,
    input  logic                 w,
    input  logic [1:0]           mode,
    input  logic                 clear_count,
    output logic                 z,
    output logic                 run_zero,
    output logic                 run_one,
    output logic [2*RUN_LEN:0]   states,
    output logic [CNT_W-1:0]     det_count,
    output logic                 onehot_err
);

    localparam int NS     = 2*RUN_LEN + 1;
    localparam int IDLE_B = 0;
    localparam int Z1_B   = 1;
    localparam int ZN_B   = RUN_LEN;
    localparam int O1_B   = RUN_LEN + 1;
    localparam int ON_B   = 2*RUN_LEN;

    localparam logic [NS-1:0]    IDLE_STATE = NS'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [NS-1:0]    states_q,     states_d;
    logic [CNT_W-1:0] det_count_q,  det_count_d;
    logic             onehot_err_q, onehot_err_d;
    logic             onehot_ok;
    logic             det_event;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            states_q     <= IDLE_STATE;
            det_count_q  <= '0;
            onehot_err_q <= 1'b0;
        end else begin
            states_q     <= states_d;
            det_count_q  <= det_count_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        states_d     = states_q;
        onehot_err_d = 1'b0;
        det_event    = 1'b0;
        onehot_ok    = $onehot(states_q);

        if (!onehot_ok) begin
            // Corrupted register: park in IDLE whatever the input is doing.
            states_d     = IDLE_STATE;
            onehot_err_d = 1'b1;
        end else if (w_valid) begin
            states_d = '0;
            if (!w) begin
                // Advance the zero run; any other state restarts it at Z1.
                for (int k = Z1_B; k < ZN_B; k++) begin
                    if (states_q[k]) states_d[k+1] = 1'b1;
                end
                if (states_q[ZN_B]) states_d[ZN_B] = 1'b1;
                if (!(|states_q[ZN_B:Z1_B])) states_d[Z1_B] = 1'b1;
            end else begin
                for (int k = O1_B; k < ON_B; k++) begin
                    if (states_q[k]) states_d[k+1] = 1'b1;
                end
                if (states_q[ON_B]) states_d[ON_B] = 1'b1;
                if (!(|states_q[ON_B:O1_B])) states_d[O1_B] = 1'b1;
            end
            // Only entering a terminal state counts; dwelling there does not.
            det_event = (states_d[ZN_B] & ~states_q[ZN_B] & mode[0]) |
                        (states_d[ON_B] & ~states_q[ON_B] & mode[1]);
        end

        det_count_d = det_count_q;
        if (clear_count) begin
            det_count_d = '0;
        end else if (det_event && (det_count_q != CNT_MAX)) begin
            det_count_d = det_count_q + CNT_W'(1);
        end
    end

    // Output decode (mode is the only combinational input to z)
    always_comb begin
        z          = (states_q[ZN_B] & mode[0]) | (states_q[ON_B] & mode[1]);
        run_zero   = states_q[ZN_B];
        run_one    = states_q[ON_B];
        states     = states_q;
        det_count  = det_count_q;
        onehot_err = onehot_err_q;
    end

    logic unused_idle;
    assign unused_idle = states_q[IDLE_B];

endmodule

// File: tb/tb_run_detect_fsm.sv
// tb_run_detect_fsm
//   Directed bench for run_detect_fsm with two instances:
//   dut_a: RUN_LEN=3, CNT_W=8 (reset, long run, mid-run reset, integrity)
//   dut_b: RUN_LEN=2, CNT_W=2 (alternation, mode masking, qualifier, counter)
module tb_run_detect_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A signals
    logic       a_reset, a_wv, a_w, a_clr;
    logic [1:0] a_mode;
    logic       a_z, a_rz, a_ro, a_err;
    logic [6:0] a_st;
    logic [7:0] a_cnt;

    // Instance B signals
    logic       b_reset, b_wv, b_w, b_clr;
    logic [1:0] b_mode;
    logic       b_z, b_rz, b_ro, b_err;
    logic [4:0] b_st;
    logic [1:0] b_cnt;

    run_detect_fsm #(.RUN_LEN(3), .CNT_W(8)) dut_a (
        .clk(clk), .reset(a_reset), .w_valid(a_wv), .w(a_w), .mode(a_mode),
        .clear_count(a_clr), .z(a_z), .run_zero(a_rz), .run_one(a_ro),
        .states(a_st), .det_count(a_cnt), .onehot_err(a_err)
    );

    run_detect_fsm #(.RUN_LEN(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(b_reset), .w_valid(b_wv), .w(b_w), .mode(b_mode),
        .clear_count(b_clr), .z(b_z), .run_zero(b_rz), .run_one(b_ro),
        .states(b_st), .det_count(b_cnt), .onehot_err(b_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic a_step(input logic wv, input logic w);
        a_wv = wv;
        a_w  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic b_step(input logic wv, input logic w);
        b_wv = wv;
        b_w  = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset = 1'b1; a_wv = 1'b0; a_w = 1'b0; a_clr = 1'b0; a_mode = 2'b11;
        b_reset = 1'b1; b_wv = 1'b0; b_w = 1'b0; b_clr = 1'b0; b_mode = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_reset = 1'b0;
        b_reset = 1'b0;

        // ---------------- Instance A, RUN_LEN=3 ----------------
        check_eq("a_reset_states", a_st, 7'b0000001);
        check_eq("a_reset_z", a_z, 1'b0);
        check_eq("a_reset_cnt", a_cnt, 8'd0);
        check_eq("a_reset_rz", a_rz, 1'b0);
        check_eq("a_reset_ro", a_ro, 1'b0);
        check_eq("a_reset_err", a_err, 1'b0);

        a_step(1'b1, 1'b0);
        check_eq("a_z1_state", a_st, 7'b0000010);
        a_step(1'b1, 1'b0);
        check_eq("a_z2_state", a_st, 7'b0000100);
        check_eq("a_z2_z", a_z, 1'b0);
        a_step(1'b1, 1'b0);
        check_eq("a_z3_state", a_st, 7'b0001000);
        check_eq("a_z3_z", a_z, 1'b1);
        check_eq("a_z3_rz", a_rz, 1'b1);
        check_eq("a_z3_cnt", a_cnt, 8'd1);
        a_step(1'b1, 1'b0);
        a_step(1'b1, 1'b0);
        check_eq("a_hold_z", a_z, 1'b1);
        check_eq("a_hold_cnt", a_cnt, 8'd1);
        check_eq("a_hold_state", a_st, 7'b0001000);

        // Break the run with ones, then partial zero run to Z2 = Z(N-1)
        a_step(1'b1, 1'b1);
        check_eq("a_break_state", a_st, 7'b0010000);
        check_eq("a_break_z", a_z, 1'b0);
        a_step(1'b1, 1'b1);
        check_eq("a_o2_state", a_st, 7'b0100000);
        a_step(1'b1, 1'b0);
        a_step(1'b1, 1'b0);
        check_eq("a_pre_rst_state", a_st, 7'b0000100);
        check_eq("a_pre_rst_cnt", a_cnt, 8'd1);

        // Reset wins over an accepted zero that would complete the run
        a_reset = 1'b1;
        a_step(1'b1, 1'b0);
        a_reset = 1'b0;
        check_eq("a_midrst_state", a_st, 7'b0000001);
        check_eq("a_midrst_cnt", a_cnt, 8'd0);
        a_step(1'b1, 1'b0);
        a_step(1'b1, 1'b0);
        check_eq("a_post_rst_z", a_z, 1'b0);
        a_step(1'b1, 1'b0);
        check_eq("a_post_rst_z3", a_z, 1'b1);
        check_eq("a_post_rst_cnt", a_cnt, 8'd1);

        // Integrity: corrupt the register, recovery ignores w_valid=0
        force dut_a.states_q = 7'b0000110;
        #1;
        release dut_a.states_q;
        a_step(1'b0, 1'b0);
        check_eq("a_recover_state", a_st, 7'b0000001);
        check_eq("a_recover_err", a_err, 1'b1);
        check_eq("a_recover_cnt", a_cnt, 8'd1);
        check_eq("a_recover_z", a_z, 1'b0);
        a_step(1'b0, 1'b0);
        check_eq("a_err_pulse_end", a_err, 1'b0);
        check_eq("a_idle_hold", a_st, 7'b0000001);

        // ---------------- Instance B, RUN_LEN=2, CNT_W=2 ----------------
        check_eq("b_reset_states", b_st, 5'b00001);
        for (int i = 0; i < 6; i++) begin
            b_step(1'b1, (i % 2 == 0));
            check_eq("b_alt_state", b_st, (i % 2 == 0) ? 5'b01000 : 5'b00010);
            check_eq("b_alt_z", b_z, 1'b0);
        end
        check_eq("b_alt_cnt", b_cnt, 2'd0);
        b_step(1'b1, 1'b1);
        b_step(1'b1, 1'b1);
        check_eq("b_11_state", b_st, 5'b10000);
        check_eq("b_11_z", b_z, 1'b1);
        check_eq("b_11_cnt", b_cnt, 2'd1);

        // Mode masking
        b_clr = 1'b1;
        b_step(1'b0, 1'b0);
        b_clr = 1'b0;
        check_eq("b_clr_cnt", b_cnt, 2'd0);
        b_mode = 2'b01;
        b_step(1'b1, 1'b0);
        b_step(1'b1, 1'b1);
        b_step(1'b1, 1'b1);
        check_eq("b_mask_ro", b_ro, 1'b1);
        check_eq("b_mask_z", b_z, 1'b0);
        check_eq("b_mask_cnt", b_cnt, 2'd0);
        b_mode = 2'b11;
        #1;
        check_eq("b_mode_comb_z", b_z, 1'b1);
        check_eq("b_mode_cnt", b_cnt, 2'd0);

        // Qualifier
        b_mode = 2'b01;
        b_step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) b_step(1'b0, 1'b1);
        check_eq("b_qual_hold", b_st, 5'b00010);
        b_step(1'b1, 1'b0);
        check_eq("b_qual_state", b_st, 5'b00100);
        check_eq("b_qual_z", b_z, 1'b1);
        check_eq("b_qual_cnt", b_cnt, 2'd1);

        // Counter saturation and clear priority
        b_mode = 2'b11;
        b_clr = 1'b1;
        b_step(1'b0, 1'b0);
        b_clr = 1'b0;
        for (int e = 0; e < 5; e++) begin
            b_step(1'b1, (e % 2 == 0));
            b_step(1'b1, (e % 2 == 0));
            check_eq("b_sat_cnt", b_cnt, (e < 3) ? (e + 1) : 3);
        end
        b_step(1'b1, 1'b0);
        b_clr = 1'b1;
        b_step(1'b1, 1'b0);
        b_clr = 1'b0;
        check_eq("b_clr_win_cnt", b_cnt, 2'd0);
        check_eq("b_clr_win_z", b_z, 1'b1);
        check_eq("b_err_idle", b_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
